onchip_mem_arbiter: RTL and testbench
=====================================

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL provide parameter BURST_MAX, default 4, meaning the max consecutive grants to one master while the other master waits (legal range 1..15).
REQ-002 SHALL provide port clk, input, 1: the single clock for all logic.
REQ-003 SHALL provide port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL provide, for N in {0,1}: mN_address in 10 (word address); mN_byteenable in 4; mN_read in 1; mN_write in 1; mN_writedata in 32.
REQ-005 SHALL provide, for N in {0,1}: mN_waitrequest out 1; mN_readdata out 32; mN_readdatavalid out 1.
REQ-006 SHALL provide memory side: mem_address out 10; mem_byteenable out 4; mem_chipselect out 1; mem_write out 1; mem_writedata out 32; mem_clken out 1; mem_readdata in 32.
- mem_readdata is valid one clk after the address is presented (single-port RAM, unregistered output).

Function
REQ-007 SHALL treat reqN = mN_read | mN_write; if both are asserted, the access SHALL be a write.
REQ-008 SHALL grant at most one master per cycle; the granted master's address/byteenable/writedata SHALL drive mem_* combinationally, with mem_chipselect=1 and mem_write=granted write.
REQ-009 SHALL drive mN_waitrequest = reqN & ~grantN combinationally; an idle master sees waitrequest=0.
REQ-010 SHALL arbitrate round-robin: if both request, grant the master not granted last, subject to REQ-011.
REQ-011 SHALL keep a hold counter (0..BURST_MAX):
- increments on each consecutive grant to the same master;
- while the other master is idle, the current master MAY be granted indefinitely (counter saturates);
- once the counter reaches BURST_MAX and the other master requests, the grant SHALL switch;
- the counter SHALL clear on a switch.
REQ-012 SHALL implement FSM states IDLE, OWN0, OWN1:
- IDLE -> OWNx on grant to x;
- OWNx -> OWNy on a switch;
- OWNx -> IDLE on a cycle with no request.
REQ-013 SHALL register {read-accepted, owner}; one cycle after a granted read, mOwner_readdatavalid=1 and mOwner_readdata=mem_readdata.
- The non-owner's readdatavalid SHALL be 0.
- Back-to-back reads SHALL sustain one per cycle.
REQ-014 SHALL return 0 on mN_readdata whenever mN_readdatavalid=0.
REQ-015 SHALL tie mem_clken=1.
REQ-016 SHALL produce no mem_chipselect and no grant in a cycle with no request.
REQ-017 SHALL give a granted write zero-latency acceptance (waitrequest=0 that cycle) and produce no readdatavalid for it.

Reset
REQ-018 SHALL, on reset_n=0, asynchronously set:
- FSM=IDLE;
- hold counter=0;
- last-grant=m1, so m0 wins the first contention;
- all readdatavalid=0 and the read-pending register cleared.
REQ-019 SHALL discard, not deliver, a read accepted in the cycle reset asserts.
REQ-020 SHALL keep mem_chipselect=0 and mN_waitrequest=reqN while reset_n=0.

Configuration
REQ-021 SHALL support macro ONCHIP_ARB_FIXED_PRIO_EN:
- when defined, m0 always wins contention and BURST_MAX/hold counter are unused (m1 served only when m0 idle);
- when undefined, round-robin with BURST_MAX hold applies.

Structure
REQ-022 SHALL place ADDR_W=10, DATA_W=32, BE_W=4 and the FSM state enum in shared package onchip_arb_pkg.
REQ-023 SHALL implement grant selection in sub-module onchip_arb_rr (2-way round-robin picker with hold counter); datapath muxing and read-return SHALL stay in onchip_mem_arbiter.

Verification
REQ-024 Single master: m0 write addr 0x005 data 0xDEADBEEF be 0xF, then read addr 0x005 -> no waitrequest; m0_readdatavalid=1 with 0xDEADBEEF one cycle after read; m1_readdatavalid=0.
REQ-025 Contention after reset: m0 and m1 both read in the same cycle -> m0 granted first, m1_waitrequest=1 for exactly one cycle, then m1 granted; data returned to the correct master.
REQ-026 Hold limit, BURST_MAX=4: m0 and m1 both request continuously -> grant pattern m0 x4, m1 x4, m0 x4; no master waits more than 4 cycles.
REQ-027 Byte enable: write 0x11223344 be 0xF, then 0xAABBCCDD be 0x3 to addr 0x3FF -> read returns 0x1122CCDD (wrap address 0x3FF valid).
REQ-028 Reset mid-read: reset_n low in the cycle m1's read is granted -> no readdatavalid afterwards; first grant after reset goes to m0 under contention.
REQ-029 With ONCHIP_ARB_FIXED_PRIO_EN: both request for 10 cycles -> m0 granted all 10, m1_waitrequest=1 throughout.

Source files
------------

// File: rtl/onchip_arb_pkg.sv
// Shared widths and FSM encoding for the two-master on-chip memory arbiter.
// Optional feature macro: ONCHIP_ARB_FIXED_PRIO_EN (see onchip_arb_rr).
package onchip_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    // Wide enough for the largest legal BURST_MAX (15).
    localparam int HOLD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Ownership state that corresponds to granting master 'sel' (0 or 1).
    function automatic arb_state_t owner_state(input logic sel);
        return sel ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/onchip_arb_rr.sv
// Two-way grant picker for onchip_mem_arbiter.
// Default build: round-robin with a per-owner hold counter capped at BURST_MAX.
// With ONCHIP_ARB_FIXED_PRIO_EN defined: m0 always wins contention and the
// hold counter is not built.
module onchip_arb_rr
    import onchip_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4
)
(
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_q;       // master granted most recently (1 = m1)
    logic       pick_valid;   // some master is granted this cycle
    logic       pick_sel;     // which master is granted (1 = m1)

    // FSM state register and last-grant memory; last-grant resets to m1 so m0 wins first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (pick_valid) begin
                last_q <= pick_sel;
            end
        end
    end

`ifdef ONCHIP_ARB_FIXED_PRIO_EN

    // Fixed priority: m1 is served only while m0 is idle
    always_comb begin
        pick_valid = req0 | req1;
        pick_sel   = ~req0;
    end

`else

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              hold_done;
    logic              same_owner;

    assign hold_done  = (hold_q >= HOLD_W'(BURST_MAX));
    assign same_owner = (state_q == owner_state(pick_sel));

    // Round-robin pick: current owner keeps the grant until its hold expires
    always_comb begin
        pick_valid = req0 | req1;
        pick_sel   = req1;
        if (req0 && req1) begin
            case (state_q)
                ST_OWN0: pick_sel = hold_done;
                ST_OWN1: pick_sel = ~hold_done;
                default: pick_sel = ~last_q;
            endcase
        end
    end

    // Hold count for the next cycle: counts grants of the current tenure, saturating
    always_comb begin
        hold_d = '0;
        if (pick_valid) begin
            if (same_owner) begin
                hold_d = hold_done ? hold_q : hold_q + HOLD_W'(1);
            end else begin
                // A new tenure restarts the count; this cycle's grant is its first.
                hold_d = HOLD_W'(1);
            end
        end
    end

    // Hold counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

`endif

    // Next-state logic: follow the granted master, drop to IDLE when nobody asks
    always_comb begin
        state_d = ST_IDLE;
        if (pick_valid) begin
            state_d = owner_state(pick_sel);
        end
    end

    // Grant outputs: one-hot pick, suppressed while reset is asserted
    always_comb begin
        grant0 = reset_n & pick_valid & ~pick_sel;
        grant1 = reset_n & pick_valid &  pick_sel;
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Arbitrates two Avalon-MM style masters onto one single-port on-chip RAM.
// Grant selection lives in onchip_arb_rr; this level muxes the memory bus and
// routes the one-cycle-late read data back to the master that issued it.
// Optional feature macro: ONCHIP_ARB_FIXED_PRIO_EN (fixed m0 priority).
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4
)
(
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic req0;
    logic req1;
    logic grant0;
    logic grant1;
    logic rd_accept;
    logic rd_pend_q;
    logic rd_owner_q;

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign mem_clken = 1'b1;

    onchip_arb_rr #(
        .BURST_MAX (BURST_MAX)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    // Stall any requesting master that is not granted this cycle
    always_comb begin
        m0_waitrequest = req0 & ~grant0;
        m1_waitrequest = req1 & ~grant1;
    end

    // Memory-side mux: granted master drives the RAM; write wins over read
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        mem_chipselect = grant0 | grant1;
        if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end else if (grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_write      = m0_write;
        end
    end

    assign rd_accept = (grant0 & ~m0_write) | (grant1 & ~m1_write);

    // Read-pending register: remembers an accepted read and its owner for one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q  <= rd_accept;
            rd_owner_q <= grant1;
        end
    end

    // Read return: RAM output goes only to the owner, zero otherwise
    always_comb begin
        m0_readdatavalid = rd_pend_q & ~rd_owner_q;
        m1_readdatavalid = rd_pend_q &  rd_owner_q;
        m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
        m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed scoreboard bench for onchip_mem_arbiter. Define ONCHIP_ARB_FIXED_PRIO_EN
// on both bench and RTL to check the fixed-priority build.
module tb_onchip_mem_arbiter;

    localparam int unsigned BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;

    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    onchip_mem_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM model: registered address, unregistered output -------------
    // Unwritten words read back as A5000000 | address.
    logic [31:0] ram [0:1023];
    logic [1023:0] written;
    logic [31:0] ram_q;
    logic        mem_clear;

    function automatic logic [31:0] stored(input logic [9:0] a);
        return written[a] ? ram[a] : (32'hA500_0000 | {22'd0, a});
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_clear) begin
            written <= '0;
        end else if (mem_chipselect && mem_clken) begin
            ram_q <= stored(mem_address);
            if (mem_write) begin
                ram[mem_address]     <= be_merge(stored(mem_address), mem_writedata, mem_byteenable);
                written[mem_address] <= 1'b1;
            end
        end
    end
    assign mem_readdata = ram_q;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Monitor: pop an expectation whenever a master sees readdatavalid
    always @(negedge clk) begin : mon
        exp_t e;
        if (m0_readdatavalid) begin
            if (q0.size() == 0) check("m0 unexpected readdatavalid", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("m0 readdata", m0_readdata, e.data);
                check("m0 readdatavalid cycle", 32'(cyc), 32'(e.cyc));
            end
        end else check("m0 readdata idle zero", m0_readdata, 32'd0);
        if (m1_readdatavalid) begin
            if (q1.size() == 0) check("m1 unexpected readdatavalid", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("m1 readdata", m1_readdata, e.data);
                check("m1 readdatavalid cycle", 32'(cyc), 32'(e.cyc));
            end
        end else check("m1 readdata idle zero", m1_readdata, 32'd0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    endtask

    task automatic expect0(input logic [31:0] d);
        q0.push_back('{data: d, cyc: cyc + 1});
    endtask

    task automatic expect1(input logic [31:0] d);
        q1.push_back('{data: d, cyc: cyc + 1});
    endtask

    task automatic waits(input string name, input logic w0, input logic w1);
        check({name, " m0_waitrequest"}, {31'd0, m0_waitrequest}, {31'd0, w0});
        check({name, " m1_waitrequest"}, {31'd0, m1_waitrequest}, {31'd0, w1});
    endtask

    task automatic do_reset();
        idle_all();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int i0, i1;
    logic exp_m1;

    initial begin
        idle_all();
        drv0(0, 0, '0, '0, '0);
        drv1(0, 0, '0, '0, '0);
        mem_clear = 1;
        reset_n   = 1;
        #1 reset_n = 0;

        // Reset state: nothing valid, no chipselect, clken tied high, requester stalled
        m0_read = 1;
        #1;
        check("reset m0_readdatavalid", {31'd0, m0_readdatavalid}, 32'd0);
        check("reset m1_readdatavalid", {31'd0, m1_readdatavalid}, 32'd0);
        check("reset mem_chipselect", {31'd0, mem_chipselect}, 32'd0);
        check("reset mem_clken", {31'd0, mem_clken}, 32'd1);
        waits("reset", 1'b1, 1'b0);
        @(posedge clk);
        #1 mem_clear = 0;
        do_reset();

        // Contention right after reset: m0 first, m1 waits exactly one cycle
        drv0(1, 0, 10'h010, '0, 4'hF);
        drv1(1, 0, 10'h020, '0, 4'hF);
        #1;
        waits("contend c0", 1'b0, 1'b1);
        check("contend c0 mem_address", {22'd0, mem_address}, 32'h010);
        expect0(32'hA500_0010);
        step();
        m0_read = 0;
        #1;
        waits("contend c1", 1'b0, 1'b0);
        check("contend c1 mem_address", {22'd0, mem_address}, 32'h020);
        expect1(32'hA500_0020);
        step();
        idle_all();
        #1;
        check("idle mem_chipselect", {31'd0, mem_chipselect}, 32'd0);
        step();

        // Single master write then read, zero-latency write acceptance
        drv0(0, 1, 10'h005, 32'hDEAD_BEEF, 4'hF);
        #1;
        waits("m0 write", 1'b0, 1'b0);
        check("m0 write mem_write", {31'd0, mem_write}, 32'd1);
        check("m0 write mem_address", {22'd0, mem_address}, 32'h005);
        step();
        drv0(1, 0, 10'h005, '0, 4'hF);
        #1;
        waits("m0 read", 1'b0, 1'b0);
        check("m0 read mem_write", {31'd0, mem_write}, 32'd0);
        expect0(32'hDEAD_BEEF);
        step();
        idle_all();
        step();

        // Byte enables at the top word address, through m1 (read-and-write gives a write)
        drv1(1, 1, 10'h3FF, 32'h1122_3344, 4'hF);
        #1 check("m1 rd+wr mem_write", {31'd0, mem_write}, 32'd1);
        step();
        drv1(0, 1, 10'h3FF, 32'hAABB_CCDD, 4'h3);
        step();
        drv1(1, 0, 10'h3FF, '0, 4'hF);
        #1 expect1(32'h1122_CCDD);
        step();
        idle_all();
        step();

        // Continuous contention: grant pattern m0 x4, m1 x4, m0 x4 (fixed prio: m0 always)
        do_reset();
        i0 = 0; i1 = 0;
        for (int k = 0; k < 12; k++) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
            exp_m1 = 1'b0;
`else
            exp_m1 = ((k / 4) % 2) == 1;
`endif
            drv0(1, 0, 10'h100 + 10'(i0), '0, 4'hF);
            drv1(1, 0, 10'h200 + 10'(i1), '0, 4'hF);
            #1;
            waits($sformatf("hold k=%0d", k), exp_m1, ~exp_m1);
            if (exp_m1) begin
                expect1(32'hA500_0200 + 32'(i1));
                i1++;
            end else begin
                expect0(32'hA500_0100 + 32'(i0));
                i0++;
            end
            step();
        end
        idle_all();
        step();

        // m0 alone past the hold limit, then m1 arrives
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drv0(0, 1, 10'h040 + 10'(k), 32'hC0DE_0000 + 32'(k), 4'hF);
            #1 waits($sformatf("solo k=%0d", k), 1'b0, 1'b0);
            step();
        end
        drv0(0, 1, 10'h046, 32'hC0DE_0006, 4'hF);
        drv1(1, 0, 10'h041, '0, 4'hF);
        #1;
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
        waits("saturate join", 1'b0, 1'b1);
        step();
        m0_write = 0;
        #1 waits("saturate after", 1'b0, 1'b0);
        expect1(32'hC0DE_0001);
        step();
`else
        waits("saturate join", 1'b1, 1'b0);
        expect1(32'hC0DE_0001);
        step();
        m1_read = 0;
        #1 waits("saturate after", 1'b0, 1'b0);
        step();
`endif
        idle_all();
        step();

        // Reset asserted in the cycle m1's read is granted: the read is dropped
        do_reset();
        drv0(0, 1, 10'h050, 32'h1234_5678, 4'hF);
        drv1(1, 0, 10'h050, '0, 4'hF);
        #1 waits("rst c0", 1'b0, 1'b1);
        step();
        m0_write = 0;
        #1 waits("rst c1", 1'b0, 1'b0);
        #1 reset_n = 0;
        #1;
        waits("rst asserted", 1'b0, 1'b1);
        check("rst asserted mem_chipselect", {31'd0, mem_chipselect}, 32'd0);
        @(posedge clk);
        idle_all();
        @(negedge clk);
        reset_n = 1;
        step();
        check("post-reset m1_readdatavalid", {31'd0, m1_readdatavalid}, 32'd0);
        drv0(1, 0, 10'h060, '0, 4'hF);
        drv1(1, 0, 10'h050, '0, 4'hF);
        #1;
        waits("post-reset contend", 1'b0, 1'b1);
        expect0(32'hA500_0060);
        step();
        m0_read = 0;
        #1 waits("post-reset m1", 1'b0, 1'b0);
        expect1(32'h1234_5678);
        step();
        idle_all();
        repeat (3) step();

        check("m0 scoreboard drained", 32'(q0.size()), 32'd0);
        check("m1 scoreboard drained", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
